// File: rtl/dma_desc_ram_pkg.sv
// dma_desc_ram_pkg: shared types, owner encoding and read-latency helper
// for the descriptor RAM arbiter.
package dma_desc_ram_pkg;

    localparam logic OWN_RD0 = 1'b0;
    localparam logic OWN_RD1 = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } tag_t;

    function automatic int rd_lat(input bit pipelined);
        return pipelined ? 2 : 1;
    endfunction

endpackage

// File: rtl/dma_rr_arb2.sv
// dma_rr_arb2: two-way round-robin arbiter; the pointer moves only when the
// caller reports that the grant was actually used.
module dma_rr_arb2
    import dma_desc_ram_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic rr_last;

    always_comb grant = (&req) ? (rr_last ? 2'b01 : 2'b10) : req;

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) rr_last <= OWN_RD1;
        else if (advance) rr_last <= grant[1];

endmodule

// File: rtl/dma_desc_ram_arbiter.sv
// dma_desc_ram_arbiter: shares one two-port descriptor RAM between two writers
// (fixed priority) and two readers (round-robin) and routes read data back.
module dma_desc_ram_arbiter
    import dma_desc_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter bit PIPELINED  = 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  wr0_req,
    input  logic [ADDR_WIDTH-1:0] wr0_addr,
    input  logic [31:0]           wr0_data,
    output logic                  wr0_ack,
    input  logic                  wr1_req,
    input  logic [ADDR_WIDTH-1:0] wr1_addr,
    input  logic [31:0]           wr1_data,
    output logic                  wr1_ack,
    input  logic                  rd0_req,
    input  logic [ADDR_WIDTH-1:0] rd0_addr,
    output logic                  rd0_ack,
    output logic                  rd0_valid,
    input  logic                  rd1_req,
    input  logic [ADDR_WIDTH-1:0] rd1_addr,
    output logic                  rd1_ack,
    output logic                  rd1_valid,
    output logic [31:0]           rd_data,
    output logic                  ram_wen,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [31:0]           ram_wdata,
    output logic                  ram_ren,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [31:0]           ram_rdata
);

    localparam int LAT = rd_lat(PIPELINED);

    logic [1:0] grant;
    tag_t       tags [LAT];

    assign wr0_ack   = wr0_req;
    assign wr1_ack   = wr1_req & ~wr0_req;
    assign ram_wen   = wr0_req | wr1_req;
    assign ram_waddr = wr0_req ? wr0_addr : wr1_addr;
    assign ram_wdata = wr0_req ? wr0_data : wr1_data;

    dma_rr_arb2 u_arb (
        .clock   (clock),
        .resetn  (resetn),
        .req     ({rd1_req, rd0_req}),
        .advance (ram_ren),
        .grant   (grant)
    );

    // A read hitting this cycle's write address waits one cycle so it sees the new word.
    assign ram_raddr = grant[1] ? rd1_addr : rd0_addr;
    assign ram_ren   = (|grant) & ~(ram_wen & (ram_raddr == ram_waddr));
    assign rd0_ack   = ram_ren & grant[0];
    assign rd1_ack   = ram_ren & grant[1];

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            for (int i = 0; i < LAT; i++) tags[i] <= '0;
        end else begin
            tags[0] <= '{valid: ram_ren, owner: grant[1] ? OWN_RD1 : OWN_RD0};
            for (int i = 1; i < LAT; i++) tags[i] <= tags[i-1];
        end

    assign rd0_valid = tags[LAT-1].valid & (tags[LAT-1].owner == OWN_RD0);
    assign rd1_valid = tags[LAT-1].valid & (tags[LAT-1].owner == OWN_RD1);
    assign rd_data   = ram_rdata;

endmodule
